// File: rtl/bus_mux_reg_if.sv
// Bus multiplexer register interface: source data/enables in, registered bus and conflict status out.
// conflict_cnt exists only when BUS_CONFLICT_CNT_EN is defined.
interface bus_mux_reg_if #(
  parameter int unsigned N_SRC  = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned CNT_W  = 8
);
  logic [N_SRC*DATA_W-1:0] src_data;
  logic [N_SRC-1:0]        drive_en;
  logic                    bus_stall;
  logic                    conflict_clr;
  logic [DATA_W-1:0]       bus_out;
  logic [SEL_W-1:0]        bus_sel;
  logic                    bus_valid;
  logic                    conflict;
  logic                    conflict_sticky;
`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0]        conflict_cnt;
`endif

  modport master (
`ifdef BUS_CONFLICT_CNT_EN
    input  conflict_cnt,
`endif
    output src_data, drive_en, bus_stall, conflict_clr,
    input  bus_out, bus_sel, bus_valid, conflict, conflict_sticky
  );

  modport slave (
`ifdef BUS_CONFLICT_CNT_EN
    output conflict_cnt,
`endif
    input  src_data, drive_en, bus_stall, conflict_clr,
    output bus_out, bus_sel, bus_valid, conflict, conflict_sticky
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered priority bus multiplexer with multi-driver conflict reporting.
// Optional saturating conflict counter enabled by defining BUS_CONFLICT_CNT_EN.
module bus_mux_reg #(
  parameter int unsigned N_SRC  = 24,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 5,
  parameter int unsigned CNT_W  = 8
) (
  input logic          clock,
  input logic          clear,
  bus_mux_reg_if.slave bus
);

  logic [SEL_W-1:0]  selNext;
  logic [DATA_W-1:0] dataNext;
  logic              anyDrv;
  logic              multi;

  // Priority encode: scanning downward lets the lowest set index win.
  always_comb begin
    selNext  = '0;
    dataNext = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (bus.drive_en[i]) begin
        selNext  = SEL_W'(i);
        dataNext = bus.src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign anyDrv = |bus.drive_en;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi  = |(bus.drive_en & (bus.drive_en - N_SRC'(1)));

  // Bus register keeps its last value when nobody drives or the bus is stalled.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus.bus_out   <= '0;
      bus.bus_sel   <= '0;
      bus.bus_valid <= 1'b0;
    end else begin
      bus.bus_valid <= anyDrv & ~bus.bus_stall;
      if (anyDrv && !bus.bus_stall) begin
        bus.bus_out <= dataNext;
        bus.bus_sel <= selNext;
      end
    end
  end

  // Conflict pulse and sticky flag; a new conflict beats a same-cycle clear.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus.conflict        <= 1'b0;
      bus.conflict_sticky <= 1'b0;
    end else begin
      bus.conflict        <= multi;
      bus.conflict_sticky <= multi | (bus.conflict_sticky & ~bus.conflict_clr);
    end
  end

`ifdef BUS_CONFLICT_CNT_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus.conflict_cnt <= '0;
    end else if (bus.conflict_clr) begin
      bus.conflict_cnt <= multi ? CNT_W'(1) : '0;
    end else if (multi && bus.conflict_cnt != CntMax) begin
      bus.conflict_cnt <= bus.conflict_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Scoreboard bench for bus_mux_reg: directed plan items plus random traffic against a behavioural model.
module tb_bus_mux_reg;
  localparam int unsigned N_SRC  = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 5;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [DATA_W-1:0] bus;
    logic [SEL_W-1:0]  sel;
    logic              valid;
    logic              conflict;
    logic              sticky;
    logic [CNT_W-1:0]  cnt;
  } expRec;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  bus_mux_reg_if #(.N_SRC(N_SRC), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) bif ();

  bus_mux_reg #(.N_SRC(N_SRC), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bif.slave)
  );

  int checks = 0;
  int errors = 0;
  expRec expQ[$];
  logic [DATA_W-1:0] srcArr [N_SRC];

  // Reference model state
  logic [DATA_W-1:0] mBus;
  int unsigned       mSel;
  logic              mSticky;
  int unsigned       mCnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBus = '0; mSel = 0; mSticky = 1'b0; mCnt = 0;
  endtask

  task automatic randSrc();
    for (int i = 0; i < int'(N_SRC); i++) srcArr[i] = $urandom;
  endtask

  // Called at a negedge: apply inputs, predict next-edge outputs, advance to next negedge.
  task automatic step(input logic [N_SRC-1:0] de, input logic stall, input logic clr);
    expRec e;
    int nDrv;
    int low;
    nDrv = $countones(de);
    low = -1;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (de[i] && low < 0) low = i;
    end
    for (int i = 0; i < int'(N_SRC); i++) bif.src_data[i*DATA_W +: DATA_W] = srcArr[i];
    bif.drive_en = de;
    bif.bus_stall = stall;
    bif.conflict_clr = clr;

    if (!stall && nDrv > 0) begin
      mBus = srcArr[low];
      mSel = low;
    end
    if (nDrv > 1) mSticky = 1'b1;
    else if (clr) mSticky = 1'b0;
    if (clr) mCnt = (nDrv > 1) ? 1 : 0;
    else if (nDrv > 1 && mCnt < CNT_MAX) mCnt = mCnt + 1;

    e.bus = mBus;
    e.sel = SEL_W'(mSel);
    e.valid = (!stall && nDrv > 0);
    e.conflict = (nDrv > 1);
    e.sticky = mSticky;
    e.cnt = CNT_W'(mCnt);
    expQ.push_back(e);
    @(negedge clock);
  endtask

  // Monitor: compare every registered output after each active edge.
  initial begin
    expRec e;
    forever begin
      @(posedge clock);
      #1;
      if (clear && expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("bus_out", 64'(bif.bus_out), 64'(e.bus));
        chk("bus_sel", 64'(bif.bus_sel), 64'(e.sel));
        chk("bus_valid", 64'(bif.bus_valid), 64'(e.valid));
        chk("conflict", 64'(bif.conflict), 64'(e.conflict));
        chk("conflict_sticky", 64'(bif.conflict_sticky), 64'(e.sticky));
`ifdef BUS_CONFLICT_CNT_EN
        chk("conflict_cnt", 64'(bif.conflict_cnt), 64'(e.cnt));
`endif
      end
    end
  end

  initial begin
    logic [N_SRC-1:0] de;
    bif.src_data = '0;
    bif.drive_en = '0;
    bif.bus_stall = 1'b0;
    bif.conflict_clr = 1'b0;
    modelReset();
    randSrc();

    #1;
    chk("reset bus_out", 64'(bif.bus_out), 64'h0);
    chk("reset bus_sel", 64'(bif.bus_sel), 64'h0);
    chk("reset bus_valid", 64'(bif.bus_valid), 64'h0);
    chk("reset conflict", 64'(bif.conflict), 64'h0);
    chk("reset sticky", 64'(bif.conflict_sticky), 64'h0);
`ifdef BUS_CONFLICT_CNT_EN
    chk("reset cnt", 64'(bif.conflict_cnt), 64'h0);
`endif
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;

    // Single driver capture with one-cycle latency
    randSrc(); srcArr[5] = 32'hDEADBEEF;
    step(N_SRC'(1) << 5, 1'b0, 1'b0);
    chk("capture src5", 64'(bif.bus_out), 64'hDEADBEEF);
    chk("capture sel5", 64'(bif.bus_sel), 64'd5);
    // Bus keeper
    for (int k = 0; k < 3; k++) begin randSrc(); step('0, 1'b0, 1'b0); end
    chk("keeper bus_out", 64'(bif.bus_out), 64'hDEADBEEF);
    chk("keeper valid", 64'(bif.bus_valid), 64'h0);
    // Double driver: lowest index wins, conflict raised
    randSrc(); srcArr[3] = 32'h11; srcArr[20] = 32'h22;
    step((N_SRC'(1) << 3) | (N_SRC'(1) << 20), 1'b0, 1'b0);
    chk("conflict winner", 64'(bif.bus_out), 64'h11);
    randSrc(); step(N_SRC'(1) << 9, 1'b0, 1'b1);
    chk("sticky cleared", 64'(bif.conflict_sticky), 64'h0);
    randSrc(); step((N_SRC'(1) << 1) | (N_SRC'(1) << 2), 1'b0, 1'b1);
    chk("sticky set wins", 64'(bif.conflict_sticky), 64'h1);
    // Stall overrides a driver
    randSrc(); srcArr[0] = 32'h55;
    step(N_SRC'(1), 1'b1, 1'b0);
    step(N_SRC'(1), 1'b0, 1'b0);
    chk("post-stall capture", 64'(bif.bus_out), 64'h55);
    // Counter saturation across five conflict cycles
    for (int k = 0; k < 5; k++) begin randSrc(); step(N_SRC'(3) << k, 1'b0, 1'b0); end
    // Highest index alone
    randSrc(); step(N_SRC'(1) << (N_SRC - 1), 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      randSrc();
      de = '0;
      case ($urandom_range(0, 3))
        0: de = '0;
        1: de[$urandom_range(0, N_SRC - 1)] = 1'b1;
        2: begin
          de[$urandom_range(0, N_SRC - 1)] = 1'b1;
          de[$urandom_range(0, N_SRC - 1)] = 1'b1;
        end
        default: de = N_SRC'($urandom);
      endcase
      step(de, ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0));
    end

    // Async reset between edges; a capture pending during reset must be discarded
    randSrc();
    step((N_SRC'(1) << 4) | (N_SRC'(1) << 6), 1'b0, 1'b0);
    #2;
    clear = 1'b0;
    #1;
    chk("async bus_out", 64'(bif.bus_out), 64'h0);
    chk("async bus_sel", 64'(bif.bus_sel), 64'h0);
    chk("async valid", 64'(bif.bus_valid), 64'h0);
    chk("async conflict", 64'(bif.conflict), 64'h0);
    chk("async sticky", 64'(bif.conflict_sticky), 64'h0);
`ifdef BUS_CONFLICT_CNT_EN
    chk("async cnt", 64'(bif.conflict_cnt), 64'h0);
`endif
    expQ.delete();
    modelReset();
    bif.drive_en = N_SRC'(1) << 7;
    @(posedge clock);
    #1;
    chk("reset held bus_out", 64'(bif.bus_out), 64'h0);
    chk("reset held valid", 64'(bif.bus_valid), 64'h0);
    @(negedge clock);
    clear = 1'b1;
    randSrc();
    step(N_SRC'(1) << 12, 1'b0, 1'b0);
    randSrc();
    step('0, 1'b0, 1'b0);

    for (int w = 0; w < 10 && expQ.size() > 0; w++) @(negedge clock);
    chk("scoreboard drained", 64'(expQ.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
Parametrised, registered successor to the datapath bus encoder/multiplexer. It takes N_SRC one-hot source out-enables and encodes them to a select index. The selected DATA_W-bit source is captured into a bus register with one-cycle latency, and the block reports multi-driver conflicts. It sits between the register file, special registers (HI/LO/Z/PC/MDR/InPort/C-sign-extended) and all bus consumers in the CPU datapath.

Parameters:
N_SRC, 24, number of bus sources; index 0 has highest priority.
DATA_W, 32, bus and source data width.
SEL_W, 5, encoded select width; must satisfy 2**SEL_W >= N_SRC.
CNT_W, 8, conflict counter width; used only with BUS_CONFLICT_CNT_EN.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous, active-low reset.
src_data  in  N_SRC*DATA_W  flattened source values; source i occupies bits [i*DATA_W +: DATA_W].
drive_en  in  N_SRC  per-source out-enable, expected one-hot (R0out..Cout).
bus_stall  in  1  when 1, the bus register and select register hold their values.
conflict_clr  in  1  synchronous clear of the sticky conflict flag (and of the counter, if present).
bus_out  out  DATA_W  registered bus value.
bus_sel  out  SEL_W  registered index of the last source that drove the bus.
bus_valid  out  1  1 for one cycle after a cycle that had at least one driver captured.
conflict  out  1  registered pulse; 1 in the cycle after a cycle in which more than one drive_en bit was set.
conflict_sticky  out  1  latched conflict flag.
conflict_cnt  out  CNT_W  saturating conflict count; present only with BUS_CONFLICT_CNT_EN.

Behaviour:
- Reset (clear=0, asynchronous):
  - bus_out=0, bus_sel=0, bus_valid=0, conflict=0, conflict_sticky=0, conflict_cnt=0.
  - Reset asserted mid-transfer discards the pending capture.
- Encode (combinational): sel_next is the lowest index i with drive_en[i]=1. any_drv = |drive_en. multi = more than one bit of drive_en set.
- Capture at each rising edge, when not stalled:
  - If any_drv=1 and bus_stall=0: bus_out <= src_data[sel_next]; bus_sel <= sel_next; bus_valid <= 1.
  - If any_drv=0 and bus_stall=0: bus_out and bus_sel hold their values (bus keeper, no float/zero); bus_valid <= 0.
  - Latency: drive_en asserted in cycle n gives bus_out valid in cycle n+1.
- Stall: bus_stall=1 holds bus_out and bus_sel, and forces bus_valid <= 0. Stall overrides any driver.
- Conflicts:
  - conflict <= multi every cycle, independent of bus_stall.
  - On multi, the lowest-index driver still wins the capture.
- Sticky flag:
  - conflict_sticky <= 1 when multi=1.
  - It clears only when conflict_clr=1 and multi=0.
  - If multi and conflict_clr are both 1 in the same cycle, set wins and the sticky flag stays 1.
- Indices >= N_SRC are never produced. drive_en bits beyond N_SRC do not exist.
- No combinational path from any input to any output.

Optional Feature:
BUS_CONFLICT_CNT_EN
- Defined:
  - conflict_cnt port exists.
  - It increments by 1 on each cycle with multi=1 and saturates at 2**CNT_W-1 (no wrap).
  - conflict_clr resets it to 0. Simultaneous multi and conflict_clr loads 1.
- Undefined:
  - Port and counter logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset, then drive_en=1<<5 with src5=32'hDEADBEEF -> next cycle bus_out=32'hDEADBEEF, bus_sel=5, bus_valid=1, conflict=0.
- drive_en=0 for 3 cycles after the capture above -> bus_out holds 32'hDEADBEEF, bus_sel=5, bus_valid=0.
- drive_en=(1<<3)|(1<<20), src3=32'h11, src20=32'h22 -> bus_out=32'h11, bus_sel=3, conflict=1 for one cycle, conflict_sticky=1.
- Then conflict_clr=1 with a single driver -> conflict_sticky=0. Repeat with conflict_clr=1 and a double driver in the same cycle -> conflict_sticky stays 1.
- bus_stall=1 with drive_en=1<<0, src0=32'h55 -> bus_out unchanged and bus_valid=0. Release the stall -> bus_out=32'h55 one cycle later.
- clear pulsed low mid-stream (async, between edges) -> all outputs 0 immediately. With BUS_CONFLICT_CNT_EN and CNT_W=2, 5 conflict cycles -> conflict_cnt=3 (saturated).
